// File: rtl/ieee_fixed2float_seq.sv
// Sequential sign-magnitude fixed-point to IEEE-754 single converter.
// The operand is normalised one bit per clock and returned through a valid/ready handshake.
`timescale 1ns/1ps
module ieee_fixed2float_seq #(
    parameter int IW = 5,
    parameter int FW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_in,
    input  logic [IW-1:0] int_in,
    input  logic [FW-1:0] frac_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out,
    output logic          busy
);
    localparam int W  = IW + FW;
    localparam int SW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] PACK = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] EXP_BASE = 8'(127 + W - 1 - FW);

    logic [1:0]    state;
    logic [W-1:0]  m;
    logic [SW-1:0] s;
    logic          sign_r;

    logic [7:0]    exp_c;
    logic [23:0]   mfull_c;
    logic [22:0]   mant_c;
    logic          m_zero;

    assign m_zero   = (m == '0);
    assign exp_c    = EXP_BASE - {{(8-SW){1'b0}}, s};
    // Left-justify M into a 24-bit significand; the hidden one lands in bit 23.
    assign mfull_c  = 24'(m) << (24 - W);
    assign mant_c   = mfull_c[22:0];

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m         <= '0;
            s         <= '0;
            sign_r    <= 1'b0;
            out       <= 32'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_in;
                        m      <= {int_in, frac_in};
                        s      <= '0;
                        state  <= NORM;
                    end
                end
                // A zero operand passes through NORM once so that its latency
                // matches a nonzero operand with no shift (two clocks).
                NORM: begin
                    if (m[W-1] || m_zero) begin
                        state <= PACK;
                    end else begin
                        m     <= m << 1;
                        s     <= s + 1'b1;
                    end
                end
                PACK: begin
                    out       <= m_zero ? {sign_r, 31'd0} : {sign_r, exp_c, mant_c};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ieee_fixed2float_seq.sv
// Self-checking bench: directed and random operands against a real-arithmetic reference.
`timescale 1ns/1ps
module tb_ieee_fixed2float_seq;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;

    // default instance, W = 10
    logic        in_valid, in_ready, sign_in, out_valid, out_ready, busy;
    logic [4:0]  int_in, frac_in;
    logic [31:0] out;

    // wide instance, W = 24
    logic        b_in_valid, b_in_ready, b_sign_in, b_out_valid, b_out_ready, b_busy;
    logic [11:0] b_int_in, b_frac_in;
    logic [31:0] b_out;

    ieee_fixed2float_seq #(.IW(5), .FW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .int_in(int_in), .frac_in(frac_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );

    ieee_fixed2float_seq #(.IW(12), .FW(12)) dut_w (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sign_in(b_sign_in), .int_in(b_int_in), .frac_in(b_frac_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .busy(b_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: value as a real, repacked from the double encoding to single.
    function automatic logic [31:0] ref_f(input bit sg, input longint mag, input int fw);
        real         v;
        logic [63:0] bits;
        int          e;
        if (mag == 0) return {sg, 31'd0};
        v = real'(mag);
        for (int i = 0; i < fw; i++) v = v / 2.0;
        bits = $realtobits(v);
        e = int'(bits[62:52]) - 1023 + 127;
        return {sg, 8'(e), bits[51:29]};
    endfunction

    // Reference latency: two clocks plus one per leading zero of the operand.
    function automatic int ref_lat(input longint mag, input int w);
        int msb;
        if (mag == 0) return 2;
        msb = 0;
        for (int i = 0; i < w; i++) if (mag[i]) msb = i;
        return 2 + (w - 1 - msb);
    endfunction

    task automatic xact_a(input bit sg, input logic [4:0] iv, input logic [4:0] fv,
                          input logic [31:0] eout, input int elat, input string tag,
                          input bit hold);
        int          lat;
        bit          rdy_seen;
        logic [31:0] held;
        chk({tag, "_pre_in_ready"}, 64'(in_ready), 64'd1);
        sign_in = sg; int_in = iv; frac_in = fv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign_in = ~sg; int_in = 5'h15; frac_in = 5'h0a;
        lat = 0; rdy_seen = 1'b0;
        while (!out_valid && lat < 64) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_out"}, 64'(out), 64'(eout));
        chk({tag, "_in_ready_low"}, 64'(rdy_seen | in_ready), 64'd0);
        if (hold) begin
            held = out;
            in_valid = 1'b1; sign_in = 1'b1; int_in = 5'd3; frac_in = 5'd3;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_out"}, 64'(out), 64'(held));
                chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_kept"}, 64'(out), 64'(eout));
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_ignored_busy"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic xact_b(input bit sg, input logic [23:0] mag, input logic [31:0] eout,
                          input int elat, input string tag);
        int lat;
        b_sign_in = sg; {b_int_in, b_frac_in} = mag; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_out"}, 64'(b_out), 64'(eout));
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        logic [9:0]  ma;
        logic [23:0] mb;
        bit          sg;

        rst = 1'b1;
        in_valid = 1'b0; sign_in = 1'b0; int_in = '0; frac_in = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_sign_in = 1'b0; b_int_in = '0; b_frac_in = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // out_ready asserted early must not disturb an idle converter
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("early_ready_valid", 64'(out_valid), 64'd0);

        xact_a(1'b0, 5'd7,  5'b10000, 32'h40F00000, 4,  "p7_5",  1'b0);
        xact_a(1'b1, 5'd1,  5'b00000, 32'hBF800000, 6,  "m1_0",  1'b0);
        xact_a(1'b0, 5'd0,  5'b00001, 32'h3D000000, 11, "lsb",   1'b0);
        xact_a(1'b0, 5'd31, 5'd31,    32'h41FFC000, 2,  "max",   1'b0);
        xact_a(1'b1, 5'd0,  5'd0,     32'h80000000, 2,  "nzero", 1'b0);
        xact_a(1'b0, 5'd0,  5'd0,     32'h00000000, 2,  "pzero", 1'b0);
        xact_a(1'b0, 5'd7,  5'b10000, 32'h40F00000, 4,  "bp",    1'b1);

        // abort an operand mid-normalisation with an asynchronous reset
        sign_in = 1'b0; int_in = 5'd0; frac_in = 5'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out", 64'(out), 64'd0);
        #3 rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) chk("abort_no_output", 64'(out_valid), 64'd0);
        end
        xact_a(1'b0, 5'd9, 5'b01000, 32'h41140000, 3, "p9_25", 1'b0);

        for (int n = 0; n < 24; n++) begin
            sg = 1'($urandom);
            ma = (n % 8 == 7) ? 10'd0 : 10'($urandom);
            xact_a(sg, ma[9:5], ma[4:0], ref_f(sg, longint'(ma), 5),
                   ref_lat(longint'(ma), 10), $sformatf("rnd%0d", n), 1'b0);
        end

        xact_b(1'b0, 24'h000001, 32'h39800000, 25, "w24_lsb");
        xact_b(1'b0, 24'hFFFFFF, 32'h457FFFFF, 2,  "w24_max");
        for (int n = 0; n < 10; n++) begin
            sg = 1'($urandom);
            mb = 24'($urandom) >> $urandom_range(0, 23);
            xact_b(sg, mb, ref_f(sg, longint'(mb), 12), ref_lat(longint'(mb), 24),
                   $sformatf("w24_rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
